// File: rtl/shift_seq_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | shift_seq_ctrl_pkg                                                   |
// | Shared mode codes, state codes and default widths for shift units.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package shift_seq_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 5;

    localparam logic [1:0] SHIFT_SRL = 2'b00;
    localparam logic [1:0] SHIFT_SRA = 2'b01;
    localparam logic [1:0] SHIFT_SLL = 2'b10;
    localparam logic [1:0] SHIFT_ROL = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/shift_seq_ctrl_step.sv
// +----------------------------------------------------------------------+
// | shift_step                                                           |
// | Combinational single-bit shift/rotate step, reusable by shift units. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module shift_step
    import shift_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_mode)
            SHIFT_SRL: o_data = {1'b0, i_data[WIDTH-1:1]};
            SHIFT_SRA: o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
            SHIFT_SLL: o_data = {i_data[WIDTH-2:0], 1'b0};
            SHIFT_ROL: o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
            default:   o_data = i_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | shift_seq_ctrl                                                       |
// | Command sequencer stepping a shift register one bit per clock.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] amount,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_step;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_data (r_result),
        .i_mode (r_mode),
        .o_data (w_step)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_mode   <= SHIFT_SRL;
            r_result <= '0;
        end else if (clear) begin
            // Abort wins over any pending command or step in progress
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_result <= data_in;
                        r_count  <= amount;
                        r_mode   <= mode;
                        r_state  <= (amount == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_result <= w_step;
                    r_count  <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_shift_seq_ctrl                                                    |
// | Table-driven, directed and randomized checks of shift_seq_ctrl.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_shift_seq_ctrl;

    localparam int W  = 32;
    localparam int CW = 5;

    logic          clock;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  data_in;
    logic [CW-1:0] amount;
    logic [1:0]    mode;
    logic          clear;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    int n_vec;
    int n_err;

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] amt;
        logic [1:0]    md;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t tbl[10];

    shift_seq_ctrl #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .amount  (amount),
        .mode    (mode),
        .clear   (clear),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Whole-amount shift computed arithmetically, independent of stepping
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int n, input logic [1:0] m);
        logic [2*W-1:0] t;
        case (m)
            2'b00:   return d >> n;
            2'b01:   return W'($signed(d) >>> n);
            2'b10:   return d << n;
            default: begin
                t = {d, d} << n;
                return t[2*W-1:W];
            end
        endcase
    endfunction

    task automatic run_cmd(input logic [W-1:0] d, input logic [CW-1:0] a,
                           input logic [1:0] m, input logic [W-1:0] exp,
                           input bit noise, input string nm);
        int edges;
        @(negedge clock);
        data_in = d;
        amount  = a;
        mode    = m;
        start   = 1'b1;
        @(posedge clock);
        #1;
        edges   = 1;
        start   = noise ? 1'($urandom) : 1'b0;
        data_in = $urandom;
        amount  = CW'($urandom);
        mode    = 2'($urandom);
        while (!done && edges < 40) begin
            check({nm, " busy"}, W'(busy), W'(1));
            @(posedge clock);
            #1;
            edges++;
            start = noise ? 1'($urandom) : 1'b0;
        end
        start = 1'b0;
        check({nm, " latency"}, W'(edges), W'(int'(a) + 1));
        check({nm, " done busy"}, W'(busy), W'(1));
        check({nm, " result"}, result, exp);
        repeat (2) begin
            @(posedge clock);
            #1;
            check({nm, " done cleared"}, W'(done), W'(0));
            check({nm, " idle"}, W'(busy), W'(0));
            check({nm, " hold"}, result, exp);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        clear   = 1'b0;
        data_in = '0;
        amount  = '0;
        mode    = 2'b00;

        tbl[0] = '{32'h8000_00F0, 5'd4,  2'b01, 32'hF800_000F};
        tbl[1] = '{32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678};
        tbl[2] = '{32'h8000_0001, 5'd1,  2'b11, 32'h0000_0003};
        tbl[3] = '{32'h0000_0001, 5'd31, 2'b10, 32'h8000_0000};
        tbl[4] = '{32'hFF00_0000, 5'd8,  2'b00, 32'h00FF_0000};
        tbl[5] = '{32'h8000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF};
        tbl[6] = '{32'h8000_0000, 5'd31, 2'b00, 32'h0000_0001};
        tbl[7] = '{32'h7FFF_FFFF, 5'd1,  2'b01, 32'h3FFF_FFFF};
        tbl[8] = '{32'h1234_5678, 5'd4,  2'b11, 32'h2345_6781};
        tbl[9] = '{32'hA5A5_A5A5, 5'd0,  2'b00, 32'hA5A5_A5A5};

        repeat (2) @(posedge clock);
        #1;
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset result", result, '0);
        @(negedge clock);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].data, tbl[i].amt, tbl[i].md, tbl[i].exp, 1'b0, $sformatf("tbl%0d", i));
        end

        // Start pulses during SHIFT/DONE must be ignored and not queued
        run_cmd(32'hFF00_0000, 5'd8, 2'b00, 32'h00FF_0000, 1'b1, "ignored start");

        // Clear on the third SHIFT edge
        @(negedge clock);
        data_in = 32'hFFFF_FFFF;
        amount  = 5'd10;
        mode    = 2'b10;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        check("clear result", result, '0);
        check("clear busy", W'(busy), W'(0));
        check("clear done", W'(done), W'(0));
        repeat (3) begin
            @(posedge clock);
            #1;
            check("clear no done", W'(done), W'(0));
        end
        run_cmd(32'h0000_00F0, 5'd4, 2'b00, 32'h0000_000F, 1'b0, "after clear");

        // Clear together with start in IDLE drops the command
        @(negedge clock);
        data_in = 32'hDEAD_BEEF;
        amount  = 5'd3;
        start   = 1'b1;
        clear   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        clear = 1'b0;
        check("clear+start busy", W'(busy), W'(0));
        check("clear+start result", result, '0);

        // Asynchronous reset between edges during SHIFT
        @(negedge clock);
        data_in = 32'h0F0F_0F0F;
        amount  = 5'd20;
        mode    = 2'b11;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        rst_n = 1'b0;
        #1;
        check("async busy", W'(busy), W'(0));
        check("async done", W'(done), W'(0));
        check("async result", result, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        run_cmd(32'h8000_00F0, 5'd4, 2'b01, 32'hF800_000F, 1'b0, "after reset");

        for (int k = 0; k < 60; k++) begin
            logic [W-1:0]  d;
            logic [CW-1:0] a;
            logic [1:0]    m;
            d = $urandom;
            a = CW'($urandom);
            m = 2'($urandom);
            run_cmd(d, a, m, ref_shift(d, int'(a), m), 1'($urandom), $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
